seg7_bin_display: RTL
=====================

# seg7_bin_display

Parametrised successor to the team's fixed 8-bit binary-to-7-segment display top. It accepts an unsigned binary value of `WIDTH` bits through a load/busy handshake and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes `DIGITS` active-low anodes with per-digit decimal points and overflow indication. It sits between the datapath producing the value and the board's 7-segment pins.

## Interface
- `WIDTH`, 8: binary input width, 4..20.
- `DIGITS`, 3: displayed digits, 1..8.
- `REFRESH_DIV`, 100000: clk cycles each digit is lit; must be 2 or more.
- `clk` in 1: single clock; every register is clocked on the posedge.
- `rst_n` in 1: synchronous, active-low reset. It is sampled on the `clk` posedge.
- `binary` in WIDTH: value to display; sampled only on an accepted load.
- `load` in 1: conversion request.
- `dp_mask` in DIGITS: bit i=1 lights the decimal point of digit i. It is read live and is not latched.
- `busy` out 1: a conversion is in progress.
- `overflow` out 1: the displayed value needs more than DIGITS digits.
- `E` out DIGITS: anodes, active-low. Digit 0 is the least significant.
- `CA2G` out 7: segments {a,b,c,d,e,f,g}, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Internal BCD digit count: NBCD = WIDTH*3/10+1.
- Conversion FSM states:
  - IDLE: if `load`=1, capture `binary` into the shift register, clear the BCD register and the shift counter, then go to SHIFT. If `load`=0, stay in IDLE.
  - SHIFT: add 3 to each BCD nibble that is 5 or more, then shift left by 1 across {bcd, bin}. Repeat for WIDTH cycles, then go to DONE.
  - DONE: copy the low DIGITS nibbles into the display register. Set `overflow` to the OR of nibbles DIGITS..NBCD-1, or 0 when DIGITS ≥ NBCD. Go to IDLE.
- `load` is ignored in SHIFT and DONE. It is never queued.
- The display register keeps the previous value for the whole conversion, so there is no flicker.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, the digit index advances 0..DIGITS-1 and then wraps to 0.
  - The refresh counter runs independently of the FSM.
- Output drive:
  - `E[i]` is 0 only when index==i.
  - `CA2G` is the encoding of display digit[index].
  - `dp` = ~`dp_mask`[index].
  - When `overflow`=1, every digit shows a dash (7'b1111110) regardless of its value.
- Reset values:
  - FSM=IDLE, `busy`=0, `overflow`=0.
  - Display register 0, index 0, refresh counter 0.
  - `E` all 1, `CA2G`=7'h7F, `dp`=1.
  - The first anode asserts on the cycle after reset is released.
- Reset asserted mid-conversion aborts the conversion. The display register returns to 0.

## Timing
- Edge 0 samples `load`=1 in IDLE. `busy`=1 from edge 0.
- Edges 1..WIDTH perform the shifts.
- Edge WIDTH+1 updates the display register and `overflow`, and drops `busy`.
- `busy` is high for exactly WIDTH+1 cycles.
- A `load` sampled on the cycle `busy` falls is ignored, because `busy` is still 1 at that edge. Back-to-back conversions therefore cost WIDTH+2 cycles.
- `E`, `CA2G` and `dp` are registered. They change one cycle after an index or display-register update.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking.
  - Digits above the most significant nonzero digit drive `CA2G`=7'h7F.
  - Digit 0 is always shown.
  - A blanked digit still lights its `dp` if its `dp_mask` bit is set.
  - Dashes from `overflow` override blanking.
- `SEG7_LZB_EN` undefined: all DIGITS digits are shown, including leading zeros.

## Structure
- Package `seg7_pkg` holds:
  - the FSM state enum {IDLE, SHIFT, DONE};
  - segment constants for digits 0–9, BLANK (7'h7F) and DASH (7'b1111110);
  - function `seg_encode(logic [3:0])`.
- Sub-module `bin2bcd_seq` holds the FSM, the double-dabble datapath, `busy` and `overflow` generation.
- The top holds the refresh counter, the display register, blanking and the output registers.

## Test plan
All scenarios use WIDTH=8, DIGITS=3, REFRESH_DIV=4 unless stated.
- Reset: hold `rst_n`=0 for 3 cycles → `E`=3'b111, `CA2G`=7'h7F, `dp`=1, `busy`=0, `overflow`=0.
- Load 255: → `busy` high 9 cycles. Anodes cycle 110,101,011 every 4 cycles. Digits show 5,5,2 (7'b0100100, 7'b0100100, 7'b0010010).
- Load 0 with `SEG7_LZB_EN`: → digit 0 = 7'b0000001, digits 1–2 = 7'h7F. Without the macro, all three digits = 7'b0000001.
- Load 42, then pulse `load` with 99 mid-conversion: → 99 is ignored, display shows 042. `dp_mask`=3'b010 → `dp`=0 only while `E`=3'b101.
- DIGITS=2, load 100: → `overflow`=1 and both digits show 7'b1111110. A following load of 99 clears `overflow`.
- Load 200, then assert `rst_n`=0 at edge 4 of the conversion: → `busy`=0 and display 000 after reset. A new load of 7 completes normally in 9 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the 7-segment display path.
// Segment patterns are {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    function automatic logic [6:0] seg_encode(logic [3:0] d);
        case (d)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: WIDTH+1 cycles busy per load; done_o pulses with the result.
// Loads arriving while busy are dropped, never queued.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WIDTH-1:0]      binary_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  done_o,
    output logic [DIGITS*4-1:0]   bcd_o
);

    localparam int NBCD = WIDTH * 3 / 10 + 1;
    localparam int NEXT = (DIGITS > NBCD) ? DIGITS : NBCD;
    localparam int CW   = $clog2(WIDTH + 1);

    state_e              state_q;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [NBCD*4-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q;
    logic                busy_q;
    logic                ovf_q;

    logic [NBCD*4-1:0]   adj;
    logic [NEXT*4-1:0]   bcd_ext;
    logic                ovf_c;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj[NBCD*4-2:0], bin_q, 1'b0};

        // Zero-extend so the low DIGITS nibbles exist even when DIGITS > NBCD.
        bcd_ext = '0;
        bcd_ext[NBCD*4-1:0] = bcd_q;
        ovf_c = |(bcd_ext >> (DIGITS * 4));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        bin_q   <= binary_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    ovf_q   <= ovf_c;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign done_o     = (state_q == DONE);
    assign bcd_o      = bcd_ext[DIGITS*4-1:0];

endmodule

// File: rtl/seg7_bin_display.sv
// Binary to multiplexed 7-segment display; outputs registered, one cycle behind index/display.
// load accepted only while idle (see busy); SEG7_LZB_EN enables leading-zero blanking.
module seg7_bin_display
    import seg7_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    binary,
    input  logic                load,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic                busy,
    output logic                overflow,
    output logic [DIGITS-1:0]   E,
    output logic [6:0]          CA2G,
    output logic                dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                 done;
    logic [DIGITS*4-1:0]  bcd;

    logic [RW-1:0]        ref_q, ref_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DIGITS*4-1:0]  disp_q, disp_d;
    logic [DIGITS-1:0]    e_q, e_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           digit;
    logic                 blank;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .binary_i   (binary),
        .load_i     (load),
        .busy_o     (busy),
        .overflow_o (overflow),
        .done_o     (done),
        .bcd_o      (bcd)
    );

    always_comb begin
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        disp_d = done ? bcd : disp_q;

        digit = 4'd0;
        dp_d  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            e_d[i] = (idx_q != IW'(i));
            if (idx_q == IW'(i)) begin
                digit = disp_q[i*4 +: 4];
                dp_d  = ~dp_mask[i];
            end
        end

`ifdef SEG7_LZB_EN
        // Blank when this digit and everything above it is zero; digit 0 always shows.
        blank = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
        blank = 1'b0;
`endif

        if (overflow)
            seg_d = SEG_DASH;
        else if (blank)
            seg_d = SEG_BLANK;
        else
            seg_d = seg_encode(digit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            e_q    <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            ref_q  <= ref_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            e_q    <= e_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign E    = e_q;
    assign CA2G = seg_q;
    assign dp   = dp_q;

endmodule
